// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Brief    : Shares one byte-addressed memory interface between the fetch (IF)
//            and load/store (LS) ports, with masked read return and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int ROUND_ROBIN = 1,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_address,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_error,
    input  logic        ls_req,
    input  logic        ls_write,
    input  logic [3:0]  ls_frame_mask,
    input  logic [31:0] ls_address,
    input  logic [31:0] ls_wdata,
    output logic [31:0] ls_rdata,
    output logic        ls_ack,
    output logic        ls_error,
    output logic        mem_enable,
    output logic        mem_state,
    output logic [3:0]  mem_frame_mask,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic        mem_wdata_oe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_done,
    output logic        busy
);

    localparam int                c_CNT_W = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_owner_ls;
    logic                 r_last_ls;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_grant_ls;
    logic                 w_any_req;

    function automatic logic f_legal_mask(input logic [3:0] mask);
        case (mask)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    // Read data arrives right-aligned; keep only the lanes of the access size.
    function automatic logic [31:0] f_lane_mask(input logic [3:0] mask);
        case (mask)
            4'b1111:          return 32'hFFFF_FFFF;
            4'b0011, 4'b1100: return 32'h0000_FFFF;
            default:          return 32'h0000_00FF;
        endcase
    endfunction

    assign w_any_req = if_req | ls_req;
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_grant_ls = ls_req;
        if (if_req && ls_req) begin
            w_grant_ls = (ROUND_ROBIN != 0) ? !r_last_ls : 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state        <= IDLE;
            r_owner_ls     <= 1'b0;
            r_last_ls      <= 1'b0;
            r_count        <= '0;
            if_rdata       <= '0;
            if_ack         <= 1'b0;
            if_error       <= 1'b0;
            ls_rdata       <= '0;
            ls_ack         <= 1'b0;
            ls_error       <= 1'b0;
            mem_enable     <= 1'b0;
            mem_state      <= 1'b0;
            mem_frame_mask <= '0;
            mem_address    <= '0;
            mem_wdata      <= '0;
            mem_wdata_oe   <= 1'b0;
        end else begin
            if_ack   <= 1'b0;
            if_error <= 1'b0;
            ls_ack   <= 1'b0;
            ls_error <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_owner_ls <= w_grant_ls;
                        r_last_ls  <= w_grant_ls;
                        r_count    <= '0;
                        if (w_grant_ls && !f_legal_mask(ls_frame_mask)) begin
                            ls_ack   <= 1'b1;
                            ls_error <= 1'b1;
                            ls_rdata <= '0;
                            r_state  <= RESPOND;
                        end else begin
                            mem_enable     <= 1'b1;
                            mem_address    <= w_grant_ls ? ls_address : if_address;
                            mem_frame_mask <= w_grant_ls ? ls_frame_mask : 4'b1111;
                            mem_state      <= w_grant_ls & ls_write;
                            mem_wdata_oe   <= w_grant_ls & ls_write;
                            mem_wdata      <= w_grant_ls ? ls_wdata : 32'h0;
                            r_state        <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    r_count <= r_count + 1'b1;
                    if (mem_done || (r_count == c_LAST)) begin
                        r_state        <= RESPOND;
                        mem_enable     <= 1'b0;
                        mem_state      <= 1'b0;
                        mem_wdata_oe   <= 1'b0;
                        mem_frame_mask <= '0;
                        mem_address    <= '0;
                        mem_wdata      <= '0;
                        if (r_owner_ls) begin
                            ls_ack   <= 1'b1;
                            ls_error <= !mem_done;
                        end else begin
                            if_ack   <= 1'b1;
                            if_error <= !mem_done;
                        end
                        // Stores and timeouts leave the owner's read data untouched.
                        if (mem_done && !mem_state) begin
                            if (r_owner_ls) begin
                                ls_rdata <= mem_rdata & f_lane_mask(mem_frame_mask);
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                RESPOND: begin
                    r_count <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Brief    : Self-checking bench for memory_arbiter with a latency-programmable
//            memory responder and a transaction-level arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_address = '0;
    logic [31:0] if_rdata;
    logic        if_ack, if_error;
    logic        ls_req = 1'b0;
    logic        ls_write = 1'b0;
    logic [3:0]  ls_frame_mask = '0;
    logic [31:0] ls_address = '0;
    logic [31:0] ls_wdata = '0;
    logic [31:0] ls_rdata;
    logic        ls_ack, ls_error;
    logic        mem_enable, mem_state, mem_wdata_oe, busy;
    logic [3:0]  mem_frame_mask;
    logic [31:0] mem_address, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_done = 1'b0;

    logic [31:0] fp_if_rdata, fp_ls_rdata, fp_mem_address, fp_mem_wdata;
    logic        fp_if_ack, fp_if_error, fp_ls_ack, fp_ls_error;
    logic        fp_mem_enable, fp_mem_state, fp_mem_wdata_oe, fp_busy;
    logic [3:0]  fp_mem_frame_mask;
    logic        fp_mem_done = 1'b0;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          mem_delay = 1;
    logic        done_en = 1'b1;
    int          acc_n = 0;
    int          fp_acc_n = 0;

    always #5 CLK = ~CLK;

    memory_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(64)) dut (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_address(if_address), .if_rdata(if_rdata),
        .if_ack(if_ack), .if_error(if_error),
        .ls_req(ls_req), .ls_write(ls_write), .ls_frame_mask(ls_frame_mask),
        .ls_address(ls_address), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata),
        .ls_ack(ls_ack), .ls_error(ls_error),
        .mem_enable(mem_enable), .mem_state(mem_state), .mem_frame_mask(mem_frame_mask),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy)
    );

    memory_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(64)) dut_fp (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_address(if_address), .if_rdata(fp_if_rdata),
        .if_ack(fp_if_ack), .if_error(fp_if_error),
        .ls_req(ls_req), .ls_write(ls_write), .ls_frame_mask(ls_frame_mask),
        .ls_address(ls_address), .ls_wdata(ls_wdata), .ls_rdata(fp_ls_rdata),
        .ls_ack(fp_ls_ack), .ls_error(fp_ls_error),
        .mem_enable(fp_mem_enable), .mem_state(fp_mem_state),
        .mem_frame_mask(fp_mem_frame_mask), .mem_address(fp_mem_address),
        .mem_wdata(fp_mem_wdata), .mem_wdata_oe(fp_mem_wdata_oe),
        .mem_rdata(mem_rdata), .mem_done(fp_mem_done), .busy(fp_busy)
    );

    // Memory responder: raises done on the mem_delay-th enabled cycle.
    always @(negedge CLK) begin
        if (mem_enable) begin
            acc_n    = acc_n + 1;
            mem_done = done_en && (acc_n == mem_delay);
        end else begin
            acc_n    = 0;
            mem_done = 1'b0;
        end
        if (fp_mem_enable) begin
            fp_acc_n    = fp_acc_n + 1;
            fp_mem_done = done_en && (fp_acc_n == mem_delay);
        end else begin
            fp_acc_n    = 0;
            fp_mem_done = 1'b0;
        end
    end

    function automatic logic [31:0] size_mask(input logic [3:0] m);
        case ($countones(m))
            1:       return 32'h0000_00FF;
            2:       return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        reset  = 1'b1;
        if_req = 1'b0;
        ls_req = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output int n, output logic a_if, output logic a_ls);
        n = 0; a_if = 1'b0; a_ls = 1'b0;
        while (n < limit && !a_if && !a_ls) begin
            tick;
            n++;
            a_if = if_ack;
            a_ls = ls_ack;
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if ({if_ack, if_error, ls_ack, ls_error, mem_enable, mem_state, mem_wdata_oe, busy} !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {if_ack, if_error, ls_ack, ls_error, mem_enable, mem_state, mem_wdata_oe, busy});
        end
        n_cmp++;
        if ({if_rdata, ls_rdata, mem_address, mem_wdata, mem_frame_mask} !== 132'h0) begin
            n_fail++;
            $display("FAIL reset_data: if_rdata=%h ls_rdata=%h addr=%h wdata=%h mask=%b want all 0",
                     if_rdata, ls_rdata, mem_address, mem_wdata, mem_frame_mask);
        end
    endtask

    task automatic test_if_fetch;
        int n = 0;
        int acc = 0;
        logic fields_ok = 1'b1;
        mem_delay = 6; done_en = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        if_address = 32'h100; if_req = 1'b1;
        while (n < 20 && !if_ack) begin
            tick;
            n++;
            if (!if_ack && mem_enable) begin
                acc++;
                if (mem_frame_mask !== 4'b1111 || mem_state !== 1'b0 || mem_address !== 32'h100)
                    fields_ok = 1'b0;
            end
        end
        n_cmp++;
        if (!fields_ok || acc != 6) begin
            n_fail++;
            $display("FAIL if_access_fields: ok=%b access_cycles=%0d want ok=1 cycles=6", fields_ok, acc);
        end
        n_cmp++;
        if (n + 1 != 8) begin
            n_fail++;
            $display("FAIL if_latency: got %0d cycles want 8", n + 1);
        end
        n_cmp++;
        if (if_ack !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || if_error !== 1'b0 || ls_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL if_response: ack=%b rdata=%h err=%b ls_ack=%b want 1 deadbeef 0 0",
                     if_ack, if_rdata, if_error, ls_ack);
        end
        tick;
        if_req = 1'b0;
    endtask

    task automatic test_store;
        int n = 0;
        logic fields_ok = 1'b1;
        mem_delay = 3; mem_rdata = 32'h1234_5678;
        ls_write = 1'b1; ls_frame_mask = 4'b0011; ls_address = 32'h204; ls_wdata = 32'h0000_A55A;
        ls_req = 1'b1;
        while (n < 20 && !ls_ack) begin
            tick;
            n++;
            if (!ls_ack && (mem_enable !== 1'b1 || mem_state !== 1'b1 || mem_wdata_oe !== 1'b1 ||
                            mem_wdata !== 32'h0000_A55A || mem_address !== 32'h204 ||
                            mem_frame_mask !== 4'b0011))
                fields_ok = 1'b0;
        end
        n_cmp++;
        if (!fields_ok || n != 4) begin
            n_fail++;
            $display("FAIL store_access: fields_ok=%b ticks=%0d want 1 and 4", fields_ok, n);
        end
        n_cmp++;
        if (ls_ack !== 1'b1 || ls_error !== 1'b0 || ls_rdata !== 32'h0 || mem_wdata_oe !== 1'b0 ||
            mem_state !== 1'b0) begin
            n_fail++;
            $display("FAIL store_response: ack=%b err=%b rdata=%h oe=%b state=%b want 1 0 00000000 0 0",
                     ls_ack, ls_error, ls_rdata, mem_wdata_oe, mem_state);
        end
        tick;
        ls_req = 1'b0;
        n_cmp++;
        if (ls_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL store_ack_pulse: ack=%b want 0", ls_ack);
        end
    endtask

    task automatic test_load_byte;
        int n;
        logic a_if, a_ls;
        mem_delay = 2; mem_rdata = 32'hFFFF_FF80;
        ls_write = 1'b0; ls_frame_mask = 4'b0100; ls_address = 32'h302;
        ls_req = 1'b1;
        wait_ack(20, n, a_if, a_ls);
        n_cmp++;
        if (!a_ls || a_if || ls_rdata !== 32'h0000_0080 || ls_error !== 1'b0 || n != 3) begin
            n_fail++;
            $display("FAIL load_byte: ls_ack=%b if_ack=%b rdata=%h err=%b ticks=%0d want 1 0 00000080 0 3",
                     a_ls, a_if, ls_rdata, ls_error, n);
        end
        tick;
        ls_req = 1'b0;
    endtask

    task automatic test_illegal_mask;
        ls_write = 1'b0; ls_frame_mask = 4'b0110; ls_address = 32'h400;
        ls_req = 1'b1;
        tick;
        n_cmp++;
        if (ls_ack !== 1'b1 || ls_error !== 1'b1 || ls_rdata !== 32'h0 || mem_enable !== 1'b0 ||
            if_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_mask: ack=%b err=%b rdata=%h mem_en=%b if_ack=%b want 1 1 00000000 0 0",
                     ls_ack, ls_error, ls_rdata, mem_enable, if_ack);
        end
        tick;
        ls_req = 1'b0;
    endtask

    task automatic test_timeout;
        int n;
        logic a_if, a_ls;
        done_en = 1'b0; mem_rdata = 32'h5555_AAAA;
        if_address = 32'h300; if_req = 1'b1;
        wait_ack(100, n, a_if, a_ls);
        n_cmp++;
        if (!a_if || a_ls || n != 65) begin
            n_fail++;
            $display("FAIL timeout_latency: if_ack=%b ls_ack=%b ticks=%0d want 1 0 65", a_if, a_ls, n);
        end
        n_cmp++;
        if (if_error !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || mem_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_response: err=%b rdata=%h mem_en=%b want 1 deadbeef 0",
                     if_error, if_rdata, mem_enable);
        end
        tick;
        if_req = 1'b0;
        done_en = 1'b1;
    endtask

    task automatic test_reset_mid_access;
        int acks = 0;
        done_en = 1'b0;
        if_address = 32'h500; if_req = 1'b1;
        repeat (4) tick;
        n_cmp++;
        if (mem_enable !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_access_active: mem_en=%b busy=%b want 1 1", mem_enable, busy);
        end
        reset = 1'b1; if_req = 1'b0;
        tick;
        reset = 1'b0;
        n_cmp++;
        if ({if_ack, ls_ack, mem_enable, mem_state, mem_wdata_oe, busy} !== 6'h0 ||
            if_rdata !== 32'h0 || mem_address !== 32'h0 || mem_frame_mask !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_abort: ctrl=%b if_rdata=%h addr=%h mask=%b want all 0",
                     {if_ack, ls_ack, mem_enable, mem_state, mem_wdata_oe, busy},
                     if_rdata, mem_address, mem_frame_mask);
        end
        repeat (80) begin
            tick;
            if (if_ack || ls_ack) acks++;
        end
        n_cmp++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_no_ack: got %0d acks want 0", acks);
        end
        done_en = 1'b1;
    endtask

    task automatic test_round_robin;
        int n;
        logic a_if, a_ls;
        do_reset;
        mem_delay = 2; mem_rdata = 32'h0BAD_F00D;
        ls_write = 1'b0; ls_frame_mask = 4'b1111; ls_address = 32'h600; if_address = 32'h700;
        if_req = 1'b1; ls_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(20, n, a_if, a_ls);
            n_cmp++;
            if ({a_if, a_ls} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: if_ack,ls_ack=%b%b want %s", k, a_if, a_ls,
                         (k % 2 == 0) ? "01" : "10");
            end
            tick;
            if (a_ls) ls_address = ls_address + 32'd4;
            if (a_if) if_address = if_address + 32'd4;
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (8) tick;
    endtask

    task automatic test_fixed_priority;
        int n;
        logic f_if, f_ls;
        do_reset;
        mem_delay = 2;
        ls_write = 1'b0; ls_frame_mask = 4'b1111;
        if_req = 1'b1; ls_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0; f_if = 1'b0; f_ls = 1'b0;
            while (n < 20 && !f_if && !f_ls) begin
                tick;
                n++;
                f_if = fp_if_ack;
                f_ls = fp_ls_ack;
            end
            n_cmp++;
            if ({f_if, f_ls} !== 2'b01) begin
                n_fail++;
                $display("FAIL fixed_grant_%0d: if_ack,ls_ack=%b%b want 01", k, f_if, f_ls);
            end
            tick;
            ls_address = ls_address + 32'd4;
        end
        if_req = 1'b0; ls_req = 1'b0;
        repeat (8) tick;
    endtask

    task automatic test_random;
        logic [3:0]  legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        logic        pend_if = 1'b0, pend_ls = 1'b0, last_ls = 1'b0;
        logic        exp_ls, exp_wr, exp_err, a_if, a_ls, got_err;
        logic [31:0] exp_if_rdata = '0, exp_ls_rdata = '0, exp_addr;
        logic [3:0]  exp_mask;
        int          exp_lat, n;
        do_reset;
        for (int t = 0; t < 40; t++) begin
            if (!pend_if && $urandom_range(0, 2) != 0) begin
                pend_if    = 1'b1;
                if_address = $urandom & 32'hFFFF_FFFC;
            end
            if (!pend_ls && ($urandom_range(0, 2) != 0 || !pend_if)) begin
                pend_ls       = 1'b1;
                ls_address    = $urandom;
                ls_write      = 1'($urandom_range(0, 1));
                ls_frame_mask = legal[$urandom_range(0, 6)];
                ls_wdata      = $urandom;
            end
            if_req    = pend_if;
            ls_req    = pend_ls;
            mem_rdata = $urandom;
            done_en   = ($urandom_range(0, 9) != 0);
            mem_delay = $urandom_range(1, 8);

            exp_ls   = (pend_if && pend_ls) ? !last_ls : pend_ls;
            last_ls  = exp_ls;
            exp_wr   = exp_ls && ls_write;
            exp_addr = exp_ls ? ls_address : if_address;
            exp_mask = exp_ls ? ls_frame_mask : 4'b1111;
            exp_err  = !done_en;
            exp_lat  = done_en ? mem_delay + 1 : 65;
            if (done_en && !exp_wr) begin
                if (exp_ls) exp_ls_rdata = mem_rdata & size_mask(ls_frame_mask);
                else        exp_if_rdata = mem_rdata;
            end

            tick;
            n_cmp++;
            if (mem_enable !== 1'b1 || mem_address !== exp_addr || mem_frame_mask !== exp_mask ||
                mem_state !== exp_wr || mem_wdata_oe !== exp_wr) begin
                n_fail++;
                $display("FAIL rand_access_%0d: en=%b addr=%h mask=%b st=%b want 1 %h %b %b",
                         t, mem_enable, mem_address, mem_frame_mask, mem_state, exp_addr, exp_mask, exp_wr);
            end
            wait_ack(100, n, a_if, a_ls);
            got_err = a_ls ? ls_error : if_error;
            n_cmp++;
            if ({a_if, a_ls} !== {!exp_ls, exp_ls} || n + 1 != exp_lat || got_err !== exp_err) begin
                n_fail++;
                $display("FAIL rand_ack_%0d: if,ls=%b%b ticks=%0d err=%b want %b%b %0d %b",
                         t, a_if, a_ls, n + 1, got_err, !exp_ls, exp_ls, exp_lat, exp_err);
            end
            n_cmp++;
            if (if_rdata !== exp_if_rdata || ls_rdata !== exp_ls_rdata) begin
                n_fail++;
                $display("FAIL rand_rdata_%0d: if=%h ls=%h want %h %h",
                         t, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata);
            end
            tick;
            if (exp_ls) pend_ls = 1'b0;
            else        pend_if = 1'b0;
        end
        if_req = 1'b0; ls_req = 1'b0; done_en = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_if_fetch;
        test_store;
        test_load_byte;
        test_illegal_mask;
        test_timeout;
        test_reset_mid_access;
        test_round_robin;
        test_fixed_priority;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Shares the single byte-addressed memory interface between the instruction-fetch port (IF) and the load/store port (LS) of the core.
- Registers each request and sequences the memory interface's enable/state/frame_mask/address lines until memory_done.
- Returns masked read data with a one-cycle acknowledge, and guards against missing memory_done with a timeout.
- Sits between the fetch/LSU stages and the memory interface; the tristate data bus glue is outside this block.

Parameters:
- ROUND_ROBIN, 1: 1 = alternate grants on simultaneous requests; 0 = fixed LS priority.
- TIMEOUT, 64: maximum cycles in ACCESS waiting for mem_done before aborting; must be ≥ 8.

Ports:
- CLK  input  1  clock
- reset  input  1  synchronous active-high reset
- if_req  input  1  fetch request, held until if_ack
- if_address  input  32  fetch byte address
- if_rdata  output  32  fetched word
- if_ack  output  1  one-cycle completion pulse
- if_error  output  1  valid with if_ack; timeout occurred
- ls_req  input  1  load/store request, held until ls_ack
- ls_write  input  1  1 = store, 0 = load
- ls_frame_mask  input  4  0001/0010/0100/1000 byte, 0011/1100 half, 1111 word
- ls_address  input  32  load/store byte address
- ls_wdata  input  32  right-aligned store data
- ls_rdata  output  32  right-aligned, zero-extended load data
- ls_ack  output  1  one-cycle completion pulse
- ls_error  output  1  valid with ls_ack; timeout or illegal mask
- mem_enable  output  1  memory interface enable
- mem_state  output  1  0 = READ, 1 = WRITE
- mem_frame_mask  output  4  mask driven to memory
- mem_address  output  32  address driven to memory
- mem_wdata  output  32  store data to bus glue
- mem_wdata_oe  output  1  drive mem_wdata onto the shared bus
- mem_rdata  input  32  bus read data
- mem_done  input  1  memory completion
- busy  output  1  state != IDLE

Behaviour:
- Reset (synchronous, highest priority): state IDLE, last_grant=IF, all outputs 0, including rdata registers and the timeout counter.
- Reset during ACCESS abandons the access. mem_enable is 0 the next cycle. No ack is issued. A partially written word is not repaired.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - Evaluates if_req/ls_req each cycle.
  - Single request: granted.
  - Both requests: ROUND_ROBIN=1 grants the port not equal to last_grant; ROUND_ROBIN=0 grants LS.
  - Grant latches owner, address, mask (IF forces 1111, READ), write flag and wdata, then moves to ACCESS and sets last_grant=owner.
  - LS request with an illegal mask (any value not listed above): no memory access; goes to RESPOND with error=1 and rdata=0.
- ACCESS:
  - mem_enable=1; mem_* outputs come from the latched registers and stay stable.
  - mem_wdata_oe=ls_write latched.
  - Counter increments each cycle.
  - mem_done=1: capture mem_rdata, masked by the mask class (byte → [7:0], half → [15:0], word → [31:0], upper bits 0), into the owner's rdata; go to RESPOND, error=0.
  - Counter reaches TIMEOUT-1 without mem_done: go to RESPOND, error=1, rdata unchanged.
- RESPOND:
  - mem_enable=0 so the memory returns to its idle state.
  - Owner's ack=1 and error as determined, for exactly this cycle; counter cleared.
  - Next state IDLE.
- Handshake:
  - A transfer completes on the edge where req && ack.
  - A requester may keep req high with new request fields for a back-to-back access, which is evaluated in the following IDLE cycle.
  - Request fields change only after ack; a change of req fields while not acked is ignored (latched copy is used).
- Latency: request to ack = 1 (IDLE) + N (ACCESS cycles up to and including mem_done) + 1 (RESPOND).
- Stores do not update ls_rdata.
- The non-owner ack is always 0; if_ack and ls_ack never assert together.

Test Plan:
- After reset, if_req=1, if_address=0x100, memory model asserts mem_done on the 6th ACCESS cycle with mem_rdata=0xDEADBEEF:
  - mem_frame_mask=1111 and mem_state=0 during ACCESS.
  - if_ack one cycle after done, if_rdata=0xDEADBEEF, if_error=0; total 8 cycles.
- ls_req store, mask=0011, address=0x204, wdata=0x0000A55A:
  - mem_state=1, mem_wdata_oe=1, mem_wdata=0x0000A55A during ACCESS only.
  - ls_ack pulse; ls_rdata unchanged.
- ls_req load, mask=0100, mem_rdata=0xFFFFFF80 at done -> ls_rdata=0x00000080.
- if_req and ls_req both held high for 4 transactions, ROUND_ROBIN=1:
  - Grant order LS, IF, LS, IF.
  - With ROUND_ROBIN=0, LS is granted every time while it stays requesting.
- ls_req with mask=0110 -> no mem_enable; ls_ack with ls_error=1 two cycles after request; ls_rdata=0.
- mem_done never asserted, TIMEOUT=64 -> if_ack with if_error=1 after 64 ACCESS cycles, mem_enable low in RESPOND.
- Reset asserted mid-ACCESS -> next cycle all outputs 0, busy=0, no ack ever issued.
